// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the VGA timing slice.
// Holds the default 1024x768 raster geometry, the counter width and the
// colour-bar palette used by the optional test-pattern generator.
package vga_pkg;

  // Counter width shared by hcount/vcount and every raster compare.
  localparam int CNT_W = 11;

  // Default horizontal geometry, in pixel clocks.
  localparam int DEF_H_VIS  = 1024;
  localparam int DEF_H_FP   = 24;
  localparam int DEF_H_SYNC = 136;
  localparam int DEF_H_BP   = 160;
  localparam int DEF_H_TOT  = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  // Default vertical geometry, in lines.
  localparam int DEF_V_VIS  = 768;
  localparam int DEF_V_FP   = 3;
  localparam int DEF_V_SYNC = 6;
  localparam int DEF_V_BP   = 29;
  localparam int DEF_V_TOT  = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Colour bars across the visible width.
  localparam int N_BARS = 8;

  // Palette, 4 bits per channel as {r,g,b}.
  localparam logic [11:0] RGB_WHITE   = 12'hFFF;
  localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
  localparam logic [11:0] RGB_CYAN    = 12'h0FF;
  localparam logic [11:0] RGB_GREEN   = 12'h0F0;
  localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
  localparam logic [11:0] RGB_RED     = 12'hF00;
  localparam logic [11:0] RGB_BLUE    = 12'h00F;
  localparam logic [11:0] RGB_BLACK   = 12'h000;

  // Map a bar index (0 = leftmost) to its palette colour.
  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      3'd7:    c = RGB_BLACK;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_bar_gen.sv
// vga_bar_gen: colour-bar test pattern for the VGA timing generator.
// Fed with the *next* raster position so its registered rgb lines up with
// the registered counters in the parent. Bars are H_VIS/N_BARS pixels wide;
// for the default 1024-pixel line this is the same as selecting on
// hcount[9:7]. Blanking forces black.
module vga_bar_gen
  import vga_pkg::*;
#(
  parameter int H_VIS = DEF_H_VIS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] hcount_i,
  input  logic             hblnk_i,
  input  logic             vblnk_i,
  output logic [11:0]      rgb_o
);

  localparam int BAR_W = H_VIS / N_BARS;

  if (BAR_W < 1) begin : g_bad_width
    $error("vga_bar_gen: H_VIS too small for the colour bars");
  end

  logic [2:0]  bar_idx;
  logic [11:0] rgb_d;
  logic [11:0] rgb_q;

  // Bar index = number of bar boundaries already passed on this line.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < N_BARS; k++) begin
      bar_idx = bar_idx + {2'b00, (hcount_i >= CNT_W'(k * BAR_W))};
    end
  end

  // Pick the palette colour, black during either blanking interval.
  always_comb begin
    rgb_d = RGB_BLACK;
    if (hblnk_i || vblnk_i) begin
      rgb_d = RGB_BLACK;
    end else begin
      rgb_d = bar_colour(bar_idx);
    end
  end

  // Register the colour so it is valid in the same cycle as the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= 12'h000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster timing generator.
// Produces pixel/line counters, sync, blanking, a frame-start pulse and a
// frame counter. Every output is a register loaded from the next counter
// values, so all outputs describe the same pixel in the same cycle.
// Build option: define VGA_TIMING_TESTPATTERN_EN to drive rgb with colour
// bars from vga_bar_gen; otherwise rgb is constant black.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start,
  output logic [15:0]      frame_cnt,
  output logic [11:0]      rgb
);

  localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (H_TOT > CNT_MAX || V_TOT > CNT_MAX) begin : g_bad_geometry
    $error("vga_timing: raster totals exceed the 11-bit counter range");
  end

  // Raster landmarks as 11-bit unsigned constants.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vblnk_q, vblnk_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             frame_wrap;

  // Next raster position: step along the line, then down, then wrap to (0,0).
  always_comb begin
    hcount_d   = hcount_q + 11'd1;
    vcount_d   = vcount_q;
    frame_wrap = 1'b0;
    if (hcount_q == H_LAST) begin
      hcount_d = 11'd0;
      if (vcount_q == V_LAST) begin
        vcount_d   = 11'd0;
        frame_wrap = 1'b1;
      end else begin
        vcount_d = vcount_q + 11'd1;
      end
    end else begin
      vcount_d = vcount_q;
    end
  end

  // Sync, blanking and frame bookkeeping for the next raster position.
  always_comb begin
    hsync_d       = ((hcount_d >= HS_START) && (hcount_d < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d       = ((vcount_d >= VS_START) && (vcount_d < VS_END)) ? VS_POL : ~VS_POL;
    hblnk_d       = (hcount_d >= H_VIS_C);
    vblnk_d       = (vcount_d >= V_VIS_C);
    frame_start_d = frame_wrap;
    frame_cnt_d   = frame_cnt_q + {15'd0, frame_wrap};
  end

  // State and output registers; reset parks the raster at (0,0), syncs idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

`ifdef VGA_TIMING_TESTPATTERN_EN
  vga_bar_gen #(
    .H_VIS (H_VIS)
  ) u_bar_gen (
    .clk      (clk),
    .rst      (rst),
    .hcount_i (hcount_d),
    .hblnk_i  (hblnk_d),
    .vblnk_i  (vblnk_d),
    .rgb_o    (rgb)
  );
`else
  assign rgb = 12'h000;
`endif

endmodule
